// File: rtl/regfile_master.sv
// Command-driven sequencer for the 8-entry register file: WRITE/READ/ADD/FLAG over valid/ready.
// Optional one-entry command skid buffer enabled by defining REGFILE_MASTER_SKID_EN.
module regfile_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdOp,
  input  logic [ADDR_W-1:0] cmdDst,
  input  logic [ADDR_W-1:0] cmdSrcA,
  input  logic [ADDR_W-1:0] cmdSrcB,
  input  logic [DATA_W-1:0] cmdData,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspA,
  output logic [DATA_W-1:0] rspB,
  output logic              enableWrite,
  output logic [ADDR_W-1:0] registerA,
  output logic [ADDR_W-1:0] registerB,
  output logic [ADDR_W-1:0] registerWrite,
  output logic [DATA_W-1:0] dataIn,
  output logic              flag,
  input  logic [DATA_W-1:0] regA,
  input  logic [DATA_W-1:0] regB,
  input  logic              flagBit
);

  typedef enum logic [1:0] {IDLE, READ, WB, RESP} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_FLAG  = 2'b11;

  state_t              state, nextState, firstState;
  logic [1:0]          opL;
  logic [ADDR_W-1:0]   dstL;
  logic                carryL;
  logic                accept, done, launch;
  logic [1:0]          lOp;
  logic [ADDR_W-1:0]   lDst, lSrcA, lSrcB;
  logic [DATA_W-1:0]   lData;
  logic [DATA_W:0]     sumFull;

  function automatic logic [DATA_W:0] addWithCarry(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign sumFull = addWithCarry(regA, regB);
  assign accept  = cmdValid & cmdReady;
  assign done    = ((state == WB) && (opL == OP_WRITE)) || ((state == RESP) && rspReady);

`ifdef REGFILE_MASTER_SKID_EN
  logic              bufValid, takeCmd;
  logic [1:0]        bufOp;
  logic [ADDR_W-1:0] bufDst, bufSrcA, bufSrcB;
  logic [DATA_W-1:0] bufData;

  // An incoming command launches directly when the FSM is free this edge; otherwise it parks.
  assign cmdReady = ~bufValid;
  assign takeCmd  = accept & ((state == IDLE) | (done & ~bufValid));
  assign launch   = (done & bufValid) | takeCmd;
  assign lOp      = bufValid ? bufOp   : cmdOp;
  assign lDst     = bufValid ? bufDst  : cmdDst;
  assign lSrcA    = bufValid ? bufSrcA : cmdSrcA;
  assign lSrcB    = bufValid ? bufSrcB : cmdSrcB;
  assign lData    = bufValid ? bufData : cmdData;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bufValid <= 1'b0;
    end else if (accept && !takeCmd) begin
      bufValid <= 1'b1;
    end else if (done && bufValid) begin
      bufValid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept && !takeCmd) begin
      bufOp   <= cmdOp;
      bufDst  <= cmdDst;
      bufSrcA <= cmdSrcA;
      bufSrcB <= cmdSrcB;
      bufData <= cmdData;
    end
  end
`else
  assign cmdReady = (state == IDLE);
  assign launch   = accept;
  assign lOp      = cmdOp;
  assign lDst     = cmdDst;
  assign lSrcA    = cmdSrcA;
  assign lSrcB    = cmdSrcB;
  assign lData    = cmdData;
`endif

  assign firstState = (lOp == OP_WRITE) ? WB : READ;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (launch) nextState = firstState;
      READ: nextState = (opL == OP_ADD) ? WB : RESP;
      WB: begin
        if (opL != OP_WRITE) nextState = RESP;
        else if (launch)     nextState = firstState;
        else                 nextState = IDLE;
      end
      RESP: if (rspReady) nextState = launch ? firstState : IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign enableWrite = (state == WB);
  assign flag        = (state == WB) && (opL == OP_ADD) && carryL;
  assign rspValid    = (state == RESP);

  // Operands are captured at the end of READ, so an ADD whose dst aliases a source is safe.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      opL           <= OP_WRITE;
      dstL          <= '0;
      carryL        <= 1'b0;
      registerA     <= '0;
      registerB     <= '0;
      registerWrite <= '0;
      dataIn        <= '0;
      rspA          <= '0;
      rspB          <= '0;
    end else begin
      if (launch) begin
        opL  <= lOp;
        dstL <= lDst;
        if (lOp == OP_WRITE) begin
          registerWrite <= lDst;
          dataIn        <= lData;
        end else begin
          registerA <= lSrcA;
          registerB <= lSrcB;
        end
      end
      if (state == READ) begin
        case (opL)
          OP_READ: begin
            rspA <= regA;
            rspB <= regB;
          end
          OP_FLAG: begin
            rspA <= {{(DATA_W-1){1'b0}}, flagBit};
            rspB <= '0;
          end
          OP_ADD: begin
            registerWrite <= dstL;
            dataIn        <= sumFull[DATA_W-1:0];
            carryL        <= sumFull[DATA_W];
          end
          default: ;
        endcase
      end
      if ((state == WB) && (opL == OP_ADD)) begin
        rspA <= dataIn;
        rspB <= {{(DATA_W-1){1'b0}}, carryL};
      end
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
// Self-checking bench for regfile_master: vector table, hand-written corner sequences, random run.
// Includes the skid-buffer sequence when REGFILE_MASTER_SKID_EN is defined.
module tb_regfile_master;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_FLAG  = 2'b11;

  logic       clock;
  logic       resetN;
  logic       cmdValid, cmdReady;
  logic [1:0] cmdOp;
  logic [2:0] cmdDst, cmdSrcA, cmdSrcB;
  logic [7:0] cmdData;
  logic       rspValid, rspReady;
  logic [7:0] rspA, rspB;
  logic       enableWrite;
  logic [2:0] registerA, registerB, registerWrite;
  logic [7:0] dataIn;
  logic       flag;
  logic [7:0] regA, regB;
  logic       flagBit;

  regfile_master #(.DATA_W(8), .ADDR_W(3)) dut (
    .clock(clock), .resetN(resetN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdDst(cmdDst), .cmdSrcA(cmdSrcA), .cmdSrcB(cmdSrcB), .cmdData(cmdData),
    .rspValid(rspValid), .rspReady(rspReady), .rspA(rspA), .rspB(rspB),
    .enableWrite(enableWrite), .registerA(registerA), .registerB(registerB),
    .registerWrite(registerWrite), .dataIn(dataIn), .flag(flag),
    .regA(regA), .regB(regB), .flagBit(flagBit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file attached to the master
  logic [7:0] rf [8] = '{default: 8'h00};
  logic       rfFlag = 1'b0;
  assign regA    = rf[registerA];
  assign regB    = rf[registerB];
  assign flagBit = rfFlag;
  always @(posedge clock) begin
    if (enableWrite) begin
      rf[registerWrite] <= dataIn;
      rfFlag            <= flag;
    end
  end

  // Write-strobe monitor
  int         wbCount = 0;
  logic [2:0] wbAddr  = '0;
  logic [7:0] wbData  = '0;
  logic       wbFlag  = 1'b0;
  always @(negedge clock) begin
    if (enableWrite) begin
      wbCount <= wbCount + 1;
      wbAddr  <= registerWrite;
      wbData  <= dataIn;
      wbFlag  <= flag;
    end
  end

  // Reference model: architectural register contents and stored flag
  logic [7:0] refRf [8] = '{default: 8'h00};
  logic       refFlag   = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelCmd(input logic [1:0] op, input logic [2:0] dst, a, b,
                          input logic [7:0] d, output logic [7:0] expA, expB);
    int s;
    expA = 8'h00;
    expB = 8'h00;
    case (op)
      OP_WRITE: begin
        refRf[dst] = d;
        refFlag    = 1'b0;
      end
      OP_READ: begin
        expA = refRf[a];
        expB = refRf[b];
      end
      OP_ADD: begin
        s          = int'(refRf[a]) + int'(refRf[b]);
        expA       = 8'(s % 256);
        expB       = (s >= 256) ? 8'h01 : 8'h00;
        refRf[dst] = expA;
        refFlag    = (s >= 256);
      end
      default: expA = {7'b0, refFlag};
    endcase
  endtask

  // Called at #1 after a rising edge; returns at #1 after a rising edge with the FSM idle or free.
  task automatic issue(input logic [1:0] op, input logic [2:0] dst, a, b, input logic [7:0] d,
                       input int stall, output logic [7:0] ra, rb, output bit ok);
    int n;
    ok = 1'b1;
    ra = 8'h00;
    rb = 8'h00;
    rspReady = (stall == 0);
    cmdOp = op; cmdDst = dst; cmdSrcA = a; cmdSrcB = b; cmdData = d;
    cmdValid = 1'b1;
    n = 0;
    while (!cmdReady && n < 20) begin
      @(posedge clock); #1; n++;
    end
    if (!cmdReady) ok = 1'b0;
    @(posedge clock); #1;
    cmdValid = 1'b0;
    if (op == OP_WRITE) begin
      @(posedge clock); #1;
    end else begin
      n = 0;
      while (!rspValid && n < 20) begin
        @(posedge clock); #1; n++;
      end
      if (!rspValid) ok = 1'b0;
      else begin
        repeat (stall) begin
          @(posedge clock); #1;
        end
        ra = rspA;
        rb = rspB;
        rspReady = 1'b1;
        @(posedge clock); #1;
      end
    end
    rspReady = 1'b1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] dst, a, b;
    logic [7:0] d;
    logic [7:0] expA, expB;
    logic [7:0] expWbData;
    logic       expWbFlag;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [7:0] ra, rb, ma, mb, held0, held1;
    bit ok;
    int wb0;

    vecs[0]  = '{OP_WRITE, 3'd1, 3'd0, 3'd0, 8'hCA, 8'h00, 8'h00, 8'hCA, 1'b0};
    vecs[1]  = '{OP_READ,  3'd0, 3'd1, 3'd0, 8'h00, 8'hCA, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{OP_WRITE, 3'd2, 3'd0, 3'd0, 8'hF0, 8'h00, 8'h00, 8'hF0, 1'b0};
    vecs[3]  = '{OP_WRITE, 3'd3, 3'd0, 3'd0, 8'h20, 8'h00, 8'h00, 8'h20, 1'b0};
    vecs[4]  = '{OP_ADD,   3'd4, 3'd2, 3'd3, 8'h00, 8'h10, 8'h01, 8'h10, 1'b1};
    vecs[5]  = '{OP_FLAG,  3'd0, 3'd0, 3'd0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{OP_READ,  3'd0, 3'd4, 3'd4, 8'h00, 8'h10, 8'h10, 8'h00, 1'b0};
    vecs[7]  = '{OP_WRITE, 3'd2, 3'd0, 3'd0, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0};
    vecs[8]  = '{OP_ADD,   3'd2, 3'd2, 3'd2, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0};
    vecs[9]  = '{OP_READ,  3'd0, 3'd2, 3'd1, 8'h00, 8'h80, 8'hCA, 8'h00, 1'b0};
    vecs[10] = '{OP_FLAG,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{OP_ADD,   3'd5, 3'd2, 3'd2, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1};
    vecs[12] = '{OP_READ,  3'd0, 3'd5, 3'd3, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0};
    vecs[13] = '{OP_FLAG,  3'd0, 3'd0, 3'd0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[14] = '{OP_WRITE, 3'd7, 3'd0, 3'd0, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[15] = '{OP_ADD,   3'd6, 3'd7, 3'd1, 8'h00, 8'hC9, 8'h01, 8'hC9, 1'b1};
    vecs[16] = '{OP_WRITE, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[17] = '{OP_FLAG,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

    resetN = 1'b0; cmdValid = 1'b0; rspReady = 1'b1;
    cmdOp = OP_WRITE; cmdDst = '0; cmdSrcA = '0; cmdSrcB = '0; cmdData = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst cmdReady", cmdReady, 1);
    check("rst rspValid", rspValid, 0);
    check("rst rspA", rspA, 0);
    check("rst rspB", rspB, 0);
    check("rst enableWrite", enableWrite, 0);
    check("rst registerA", registerA, 0);
    check("rst registerB", registerB, 0);
    check("rst registerWrite", registerWrite, 0);
    check("rst dataIn", dataIn, 0);
    check("rst flag", flag, 0);
    resetN = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 18; i++) begin
      wb0 = wbCount;
      modelCmd(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].d, ma, mb);
      issue(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].d, 0, ra, rb, ok);
      check($sformatf("vec%0d handshake", i), ok, 1);
      if (vecs[i].op != OP_WRITE) begin
        check($sformatf("vec%0d rspA", i), ra, vecs[i].expA);
        check($sformatf("vec%0d rspB", i), rb, vecs[i].expB);
      end
      if (vecs[i].op == OP_WRITE || vecs[i].op == OP_ADD) begin
        check($sformatf("vec%0d wb pulses", i), wbCount - wb0, 1);
        check($sformatf("vec%0d wb addr", i), wbAddr, vecs[i].dst);
        check($sformatf("vec%0d wb data", i), wbData, vecs[i].expWbData);
        check($sformatf("vec%0d wb flag", i), wbFlag, vecs[i].expWbFlag);
      end else begin
        check($sformatf("vec%0d wb pulses", i), wbCount - wb0, 0);
      end
    end

    // Response backpressure: held for 5 cycles, then a single handshake
    modelCmd(OP_READ, 3'd0, 3'd1, 3'd7, 8'h00, ma, mb);
    rspReady = 1'b0;
    cmdOp = OP_READ; cmdSrcA = 3'd1; cmdSrcB = 3'd7; cmdValid = 1'b1;
    @(posedge clock); #1;
    cmdValid = 1'b0;
    @(posedge clock); #1;
    check("bp rspValid first", rspValid, 1);
    held0 = ma; held1 = mb;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold%0d valid", k), rspValid, 1);
      check($sformatf("bp hold%0d rspA", k), rspA, held0);
      check($sformatf("bp hold%0d rspB", k), rspB, held1);
      @(posedge clock); #1;
    end
    rspReady = 1'b1;
    @(posedge clock); #1;
    check("bp cmdReady after", cmdReady, 1);
    check("bp rspValid after", rspValid, 0);
    repeat (3) @(posedge clock);
    #1;
    check("bp no second rsp", rspValid, 0);

    // Reset while an ADD is in its READ cycle
    wb0 = wbCount;
    cmdOp = OP_ADD; cmdDst = 3'd6; cmdSrcA = 3'd1; cmdSrcB = 3'd2; cmdValid = 1'b1;
    check("rr ready before", cmdReady, 1);
    @(posedge clock); #1;
    cmdValid = 1'b0;
    resetN = 1'b0;
    #1;
    check("rr enableWrite", enableWrite, 0);
    check("rr rspValid", rspValid, 0);
    check("rr cmdReady", cmdReady, 1);
    @(posedge clock); #1;
    resetN = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rr no write", wbCount - wb0, 0);
    check("rr no rsp", rspValid, 0);
    check("rr cmdReady after", cmdReady, 1);
    modelCmd(OP_READ, 3'd0, 3'd6, 3'd6, 8'h00, ma, mb);
    issue(OP_READ, 3'd0, 3'd6, 3'd6, 8'h00, 0, ra, rb, ok);
    check("rr readback ok", ok, 1);
    check("rr target unchanged", ra, ma);

`ifdef REGFILE_MASTER_SKID_EN
    // READ then WRITE on consecutive edges; WRITE strobes right after the READ handshake
    modelCmd(OP_READ, 3'd0, 3'd1, 3'd2, 8'h00, ma, mb);
    rspReady = 1'b1;
    cmdOp = OP_READ; cmdSrcA = 3'd1; cmdSrcB = 3'd2; cmdValid = 1'b1;
    @(posedge clock); #1;
    cmdOp = OP_WRITE; cmdDst = 3'd3; cmdData = 8'h5A;
    check("skid ready busy", cmdReady, 1);
    @(posedge clock); #1;
    cmdValid = 1'b0;
    check("skid rspValid", rspValid, 1);
    check("skid rspA", rspA, ma);
    check("skid rspB", rspB, mb);
    modelCmd(OP_WRITE, 3'd3, 3'd0, 3'd0, 8'h5A, ma, mb);
    @(posedge clock); #1;
    check("skid wb enable", enableWrite, 1);
    check("skid wb addr", registerWrite, 3'd3);
    check("skid wb data", dataIn, 8'h5A);
    @(posedge clock); #1;
    check("skid done", enableWrite | rspValid, 0);
`endif

    // Random commands against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      logic [2:0] dst, a, b;
      logic [7:0] d;
      int stall;
      op    = 2'($urandom_range(0, 3));
      dst   = 3'($urandom_range(0, 7));
      a     = 3'($urandom_range(0, 7));
      b     = 3'($urandom_range(0, 7));
      d     = 8'($urandom_range(0, 255));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      modelCmd(op, dst, a, b, d, ma, mb);
      issue(op, dst, a, b, d, stall, ra, rb, ok);
      if (!ok) check($sformatf("rnd%0d handshake", i), ok, 1);
      if (op != OP_WRITE) begin
        check($sformatf("rnd%0d op%0d rspA", i, op), ra, ma);
        check($sformatf("rnd%0d op%0d rspB", i, op), rb, mb);
      end
    end
    for (int r = 0; r < 8; r++) check($sformatf("final r%0d", r), rf[r], refRf[r]);
    check("final flag", rfFlag, refFlag);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_master.md
# regfile_master

Command-driven initiator for the 8-entry register file: accepts write/read/add/flag-read commands over a valid/ready handshake, sequences the register file's read ports, write port and flag input, and returns read results over a second valid/ready handshake. It sits between a controller or testbench-level sequencer and the register file, and lets higher-level logic access the register file without hand-timing its port strobes.

## Interface
- DATA_W, 8, data width of the register file
- ADDR_W, 3, register address width (2**ADDR_W entries)

- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- cmdValid  in  1  command present
- cmdReady  out  1  command accepted when cmdValid & cmdReady at a rising edge
- cmdOp  in  2  00 WRITE, 01 READ, 10 ADD, 11 FLAG
- cmdDst  in  ADDR_W  destination register (WRITE, ADD)
- cmdSrcA / cmdSrcB  in  ADDR_W  source registers (READ, ADD)
- cmdData  in  DATA_W  write data (WRITE)
- rspValid  out  1  response present
- rspReady  in  1  response consumed when rspValid & rspReady at a rising edge
- rspA / rspB  out  DATA_W  response data
- enableWrite  out  1  register-file write strobe
- registerA / registerB  out  ADDR_W  register-file read addresses
- registerWrite  out  ADDR_W  register-file write address
- dataIn  out  DATA_W  register-file write data
- flag  out  1  carry to the register file's flag, meaningful only while enableWrite=1
- regA / regB  in  DATA_W  register-file read data, combinational from registerA/B
- flagBit  in  1  stored flag from the register file

## Operation
- FSM states: IDLE, READ, WB, RESP. All outputs are registered or decoded from state and latched command only.
- IDLE: cmdReady=1. On accept, the command is latched and the next state is:
  - WB for WRITE
  - READ for READ, ADD and FLAG
- READ, one cycle: registerA/registerB are driven from the latched sources. At the edge, the FSM captures regA, regB and flagBit.
  - READ and FLAG -> RESP
  - ADD -> WB
- WB, one cycle: enableWrite=1 and registerWrite=dst.
  - WRITE: dataIn=cmdData, flag=0, then -> IDLE. WRITE produces no response.
  - ADD: {carry, sum} = capA + capB (DATA_W+1 bits, no saturation). dataIn=sum and flag=carry, then -> RESP.
- RESP: rspValid=1, holding until rspReady. On the handshake -> IDLE. Response contents:
  - READ: rspA=capA, rspB=capB
  - ADD: rspA=sum, rspB={0…,carry}
  - FLAG: rspA={0…,flagBit}, rspB=0
- Outside WB: enableWrite=0 and flag=0. Address and data outputs hold their last values.
- ADD with cmdDst equal to a source: the operands were captured in READ, so the write does not affect the sum.
- Reset mid-operation: the FSM goes to IDLE immediately, with no write strobe, no response, and any latched command discarded.

## Timing
- Reset values: cmdReady=1 (IDLE). rspValid, rspA, rspB, enableWrite, registerA, registerB, registerWrite, dataIn and flag are all 0.
- Latency, counted from the accept edge as cycle 0:
  - WRITE: enableWrite high in cycle 1. The register-file entry is updated at the end of cycle 1. cmdReady returns in cycle 2.
  - READ / FLAG: rspValid first high in cycle 2.
  - ADD: write in cycle 2, rspValid first high in cycle 3.
- rspA/rspB are stable while rspValid=1 and rspReady=0.
- Back-to-back READs with rspReady tied high: one command per 3 cycles without the skid buffer.

## Configuration
- REGFILE_MASTER_SKID_EN defined:
  - A one-entry command buffer is added, and cmdReady=1 whenever the buffer is empty, including while busy.
  - On completion (WB of WRITE, or the RESP handshake) with the buffer full, the FSM enters the buffered command's first state directly, skipping IDLE, and empties the buffer.
  - When the FSM is in IDLE, the buffer is always empty.
  - Reset clears the buffer.
- Not defined: no buffer, and cmdReady=1 only in IDLE.

## Test plan
- After reset, WRITE dst=1 data=0xCA, then READ srcA=1 srcB=0: enableWrite pulses for exactly one cycle with registerWrite=1 and dataIn=0xCA. Response rspA=0xCA, rspB=0x00.
- Write r2=0xF0 and r3=0x20, then ADD dst=4 srcA=2 srcB=3: the WB cycle shows dataIn=0x10 and flag=1. Response rspA=0x10, rspB=0x01. FLAG then returns rspA=0x01. A READ of r4 returns 0x10.
- ADD dst=2 srcA=2 srcB=2 with r2=0x40: response 0x80 with carry 0, and r2 reads back 0x80.
- READ with rspReady held low for 5 cycles: rspValid stays high and rspA/rspB are unchanged. On the handshake cmdReady returns the next cycle, and no second response appears.
- resetN asserted during the READ cycle of an ADD: there is no enableWrite pulse and no rspValid. After reset release the target register is unchanged and cmdReady=1.
- With REGFILE_MASTER_SKID_EN, issue READ then WRITE back-to-back, both accepted on consecutive edges, with rspReady tied high. The WRITE's enableWrite asserts in the cycle right after the READ response handshake.
